// File: rtl/lamp_controller_if.sv
// Wall-button / presence-sensor / lamp bundle for lamp_controller.
// master = stimulus side (button, sensor, timer pulse); slave = the controller.
interface lamp_controller_if;
   logic push_button;
   logic infravermelho;
   logic shutdown_pulse;
   logic lamp;
   logic timer_enable;
   logic auto_mode;

   modport master (
      output push_button,
      output infravermelho,
      output shutdown_pulse,
      input  lamp,
      input  timer_enable,
      input  auto_mode
   );

   modport slave (
      input  push_button,
      input  infravermelho,
      input  shutdown_pulse,
      output lamp,
      output timer_enable,
      output auto_mode
   );
endinterface

// File: rtl/lamp_controller.sv
// Lamp controller: button debounce, short/long press classification, manual/auto Moore FSM.
// Optional macro LAMP_MANUAL_TIMEOUT_EN lets the inactivity timer switch off a manually lit lamp.
module lamp_controller #(
   parameter int DEBOUNCE_T   = 50,
   parameter int LONG_PRESS_T = 3000
) (
   input  logic               clk,
   input  logic               rst,
   lamp_controller_if.slave   ctl,
   output logic [1:0]         dbg_state_o,
   output logic               dbg_short_o,
   output logic               dbg_long_o
);

   localparam int DB_W = $clog2(DEBOUNCE_T + 1);
   localparam int LP_W = $clog2(LONG_PRESS_T + 1);

   typedef enum logic [1:0] {
      MANUAL_OFF = 2'b00,
      MANUAL_ON  = 2'b01,
      AUTO_OFF   = 2'b10,
      AUTO_ON    = 2'b11
   } state_t;

   logic            sync1_q, sync2_q;
   logic            btn_db_q, btn_db_d;
   logic            btn_prev_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [LP_W-1:0] press_cnt_q, press_cnt_d;
   logic            long_done_q, long_done_d;
   logic            short_q, short_d;
   logic            long_q, long_d;
   logic            btn_fall;
   state_t          state_q, state_d;

   // Debounce: the level is accepted once the mismatch has lasted DEBOUNCE_T cycles.
   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (sync2_q != btn_db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_T - 1)) begin
            btn_db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      press_cnt_d = '0;
      if (btn_db_q) begin
         if (press_cnt_q == LP_W'(LONG_PRESS_T)) begin
            press_cnt_d = press_cnt_q;
         end else begin
            press_cnt_d = press_cnt_q + 1'b1;
         end
      end
   end

   // long_done remembers that this press already fired, so its release is not a short press.
   always_comb begin
      btn_fall    = btn_prev_q & ~btn_db_q;
      long_d      = btn_db_q && (press_cnt_q == LP_W'(LONG_PRESS_T)) && !long_done_q;
      short_d     = btn_fall && !long_done_q;
      long_done_d = long_done_q;
      if (long_d) begin
         long_done_d = 1'b1;
      end else if (btn_fall) begin
         long_done_d = 1'b0;
      end
   end

   // The FSM moves on the same edge that registers a strobe, which keeps the
   // release-to-lamp latency at DEBOUNCE_T+3 edges.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MANUAL_OFF: begin
            if (long_d)       state_d = AUTO_OFF;
            else if (short_d) state_d = MANUAL_ON;
         end
         MANUAL_ON: begin
            if (long_d)                  state_d = AUTO_OFF;
`ifdef LAMP_MANUAL_TIMEOUT_EN
            else if (ctl.shutdown_pulse) state_d = MANUAL_OFF;
`endif
            else if (short_d)            state_d = MANUAL_OFF;
         end
         AUTO_OFF: begin
            if (long_d)                 state_d = MANUAL_OFF;
            else if (ctl.infravermelho) state_d = AUTO_ON;
         end
         AUTO_ON: begin
            if (long_d)                  state_d = MANUAL_OFF;
            else if (ctl.shutdown_pulse) state_d = AUTO_OFF;
         end
         default: state_d = MANUAL_OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         btn_db_q    <= 1'b0;
         btn_prev_q  <= 1'b0;
         db_cnt_q    <= '0;
         press_cnt_q <= '0;
         long_done_q <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         state_q     <= MANUAL_OFF;
      end else begin
         sync1_q     <= ctl.push_button;
         sync2_q     <= sync1_q;
         btn_db_q    <= btn_db_d;
         btn_prev_q  <= btn_db_q;
         db_cnt_q    <= db_cnt_d;
         press_cnt_q <= press_cnt_d;
         long_done_q <= long_done_d;
         short_q     <= short_d;
         long_q      <= long_d;
         state_q     <= state_d;
      end
   end

   // Moore outputs, decoded from the state register alone.
   always_comb begin
      ctl.lamp         = 1'b0;
      ctl.timer_enable = 1'b0;
      ctl.auto_mode    = 1'b0;
      case (state_q)
         MANUAL_ON: begin
            ctl.lamp = 1'b1;
`ifdef LAMP_MANUAL_TIMEOUT_EN
            ctl.timer_enable = 1'b1;
`else
            ctl.timer_enable = 1'b0;
`endif
         end
         AUTO_OFF: ctl.auto_mode = 1'b1;
         AUTO_ON: begin
            ctl.lamp         = 1'b1;
            ctl.timer_enable = 1'b1;
            ctl.auto_mode    = 1'b1;
         end
         default: ;
      endcase
   end

   assign dbg_state_o = state_q;
   assign dbg_short_o = short_q;
   assign dbg_long_o  = long_q;

endmodule

// File: tb/tb_lamp_controller.sv
// Directed bench for lamp_controller with DEBOUNCE_T=4, LONG_PRESS_T=20.
module tb_lamp_controller;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   logic       dbg_short, dbg_long;
   int         compared   = 0;
   int         mismatched = 0;
   int         shorts     = 0;
   int         longs      = 0;
   int         s0, l0;
   logic       exp_lamp_after_sd;
   logic [1:0] exp_state_after_sd;
   logic       exp_timer_man;

   localparam logic [1:0] ST_MOFF = 2'd0;
   localparam logic [1:0] ST_MON  = 2'd1;
   localparam logic [1:0] ST_AOFF = 2'd2;
   localparam logic [1:0] ST_AON  = 2'd3;

   always #5 clk = ~clk;

   lamp_controller_if ctl();

   lamp_controller #(
      .DEBOUNCE_T   (4),
      .LONG_PRESS_T (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ctl         (ctl),
      .dbg_state_o (dbg_state),
      .dbg_short_o (dbg_short),
      .dbg_long_o  (dbg_long)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n clocks; inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         shorts += int'(dbg_short);
         longs  += int'(dbg_long);
      end
   endtask

   task automatic press(input int hold);
      ctl.push_button = 1'b1;
      tick(hold);
      ctl.push_button = 1'b0;
   endtask

   initial begin
`ifdef LAMP_MANUAL_TIMEOUT_EN
      exp_lamp_after_sd  = 1'b0;
      exp_state_after_sd = ST_MOFF;
      exp_timer_man      = 1'b1;
`else
      exp_lamp_after_sd  = 1'b1;
      exp_state_after_sd = ST_MON;
      exp_timer_man      = 1'b0;
`endif
      rst = 1'b1;
      ctl.push_button    = 1'b0;
      ctl.infravermelho  = 1'b0;
      ctl.shutdown_pulse = 1'b0;
      #2;
      check("rst_lamp",  ctl.lamp, 0);
      check("rst_timer", ctl.timer_enable, 0);
      check("rst_auto",  ctl.auto_mode, 0);
      check("rst_state", dbg_state, ST_MOFF);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Clean 20-cycle press: lamp rises on the 7th edge after release.
      press(20);
      tick(6);
      check("lat_lamp_early", ctl.lamp, 0);
      tick(1);
      check("lat_lamp_on", ctl.lamp, 1);
      check("lat_state", dbg_state, ST_MON);
      check("lat_auto", ctl.auto_mode, 0);
      check("lat_shorts", shorts, 1);
      check("lat_longs", longs, 0);
      tick(5);

      // Bouncing press: one short strobe, lamp toggles off.
      s0 = shorts;
      ctl.push_button = 1'b1; tick(2);
      ctl.push_button = 1'b0; tick(2);
      press(12);
      tick(15);
      check("bounce_shorts", shorts - s0, 1);
      check("bounce_lamp", ctl.lamp, 0);
      check("bounce_state", dbg_state, ST_MOFF);

      // Long press into automatic mode; release adds nothing.
      l0 = longs;
      s0 = shorts;
      ctl.push_button = 1'b1;
      tick(40);
      check("long_state_held", dbg_state, ST_AOFF);
      check("long_auto_held", ctl.auto_mode, 1);
      check("long_lamp_held", ctl.lamp, 0);
      check("long_count", longs - l0, 1);
      ctl.push_button = 1'b0;
      tick(15);
      check("long_state_rel", dbg_state, ST_AOFF);
      check("long_no_short", shorts - s0, 0);
      ctl.infravermelho = 1'b1;
      tick(1);
      check("ir_lamp", ctl.lamp, 1);
      check("ir_timer", ctl.timer_enable, 1);
      check("ir_state", dbg_state, ST_AON);

      // Shutdown in AUTO_ON, then short press ignored in AUTO_OFF.
      ctl.infravermelho = 1'b0;
      tick(2);
      check("aon_hold_lamp", ctl.lamp, 1);
      ctl.shutdown_pulse = 1'b1;
      tick(1);
      ctl.shutdown_pulse = 1'b0;
      check("sd_lamp", ctl.lamp, 0);
      check("sd_state", dbg_state, ST_AOFF);
      check("sd_auto", ctl.auto_mode, 1);
      s0 = shorts;
      press(8);
      tick(15);
      check("aoff_short_seen", shorts - s0, 1);
      check("aoff_short_state", dbg_state, ST_AOFF);
      check("aoff_short_lamp", ctl.lamp, 0);

      // Shutdown together with presence: off for one cycle, then back on.
      ctl.infravermelho = 1'b1;
      tick(1);
      check("ir2_lamp", ctl.lamp, 1);
      ctl.shutdown_pulse = 1'b1;
      tick(1);
      ctl.shutdown_pulse = 1'b0;
      check("sd_ir_state", dbg_state, ST_AOFF);
      check("sd_ir_lamp", ctl.lamp, 0);
      tick(1);
      check("sd_ir_back_state", dbg_state, ST_AON);
      check("sd_ir_back_lamp", ctl.lamp, 1);

      // Long press in AUTO_ON returns to manual; presence then ignored.
      press(30);
      check("aon_long_state", dbg_state, ST_MOFF);
      check("aon_long_auto", ctl.auto_mode, 0);
      check("aon_long_lamp", ctl.lamp, 0);
      tick(15);
      check("moff_ir_ignored", dbg_state, ST_MOFF);
      ctl.infravermelho = 1'b0;
      tick(2);

      // Shutdown pulse while MANUAL_ON.
      press(10);
      tick(10);
      check("mon_lamp", ctl.lamp, 1);
      check("mon_timer", ctl.timer_enable, exp_timer_man);
      ctl.shutdown_pulse = 1'b1;
      tick(1);
      ctl.shutdown_pulse = 1'b0;
      check("mon_sd_lamp", ctl.lamp, exp_lamp_after_sd);
      check("mon_sd_state", dbg_state, exp_state_after_sd);
      tick(2);

      // Reset mid-press in AUTO_ON; button held across release is a fresh press.
      press(30);
      tick(10);
      check("pre_rst_state", dbg_state, ST_AOFF);
      ctl.infravermelho = 1'b1;
      tick(1);
      check("pre_rst_aon", dbg_state, ST_AON);
      ctl.push_button = 1'b1;
      tick(10);
      rst = 1'b1;
      #1;
      check("mid_rst_lamp", ctl.lamp, 0);
      check("mid_rst_timer", ctl.timer_enable, 0);
      check("mid_rst_auto", ctl.auto_mode, 0);
      check("mid_rst_state", dbg_state, ST_MOFF);
      tick(1);
      rst = 1'b0;
      s0 = shorts;
      tick(3);
      ctl.push_button = 1'b0;
      tick(15);
      check("post_rst_no_press", shorts - s0, 0);
      check("post_rst_state", dbg_state, ST_MOFF);
      ctl.infravermelho = 1'b0;
      tick(2);
      press(10);
      tick(6);
      check("post_rst_lat_early", ctl.lamp, 0);
      tick(1);
      check("post_rst_lat_on", ctl.lamp, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
